// File: rtl/md_unit_e_if.sv
// md_unit_e_if: E-stage instruction/operand bus and HI/LO result bus of the multiply/divide unit
interface md_unit_e_if;
  logic [5:0]  IR_OP;
  logic [5:0]  IR_FUNC;
  logic        IR_VALID;
  logic [31:0] A;
  logic [31:0] B;
  logic        START;
  logic        BUSY;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_OUT;
  modport master (
    output IR_OP, IR_FUNC, IR_VALID, A, B,
    input  START, BUSY, HI, LO, MD_OUT
  );
  modport slave (
    input  IR_OP, IR_FUNC, IR_VALID, A, B,
    output START, BUSY, HI, LO, MD_OUT
  );
endinterface

// File: rtl/md_unit_e.sv
// md_unit_e: E-stage multiply/divide unit owning HI/LO with a cycle-counted busy window
module md_unit_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        rst_n,
  md_unit_e_if.slave md
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy, res_we;
  logic [31:0]   hi, lo, res_hi, res_lo;
  logic          dec, is_mul, is_div, is_mthi, is_mtlo, sgn, start;
  logic [63:0]   mul_a, mul_b, prod;
  logic [31:0]   mag_a, mag_b, q, r, quo, rem;
  // decode plus a sign-magnitude datapath so the signed overflow case needs no special handling
  always_comb begin
    dec     = md.IR_VALID && md.IR_OP == 6'h00;
    is_mul  = dec && (md.IR_FUNC == 6'h18 || md.IR_FUNC == 6'h19);
    is_div  = dec && (md.IR_FUNC == 6'h1A || md.IR_FUNC == 6'h1B);
    is_mthi = dec && md.IR_FUNC == 6'h11;
    is_mtlo = dec && md.IR_FUNC == 6'h13;
    start   = state == IDLE && (is_mul || is_div);
    sgn     = !md.IR_FUNC[0];
    mul_a   = {{32{sgn & md.A[31]}}, md.A};
    mul_b   = {{32{sgn & md.B[31]}}, md.B};
    prod    = mul_a * mul_b;
    mag_a   = sgn && md.A[31] ? -md.A : md.A;
    mag_b   = sgn && md.B[31] ? -md.B : md.B;
    q       = mag_b == 32'd0 ? 32'd0 : mag_a / mag_b;
    r       = mag_b == 32'd0 ? 32'd0 : mag_a % mag_b;
    quo     = sgn && (md.A[31] ^ md.B[31]) ? -q : q;
    rem     = sgn && md.A[31] ? -r : r;
  end
  assign md.START  = start;
  assign md.BUSY   = busy;
  assign md.HI     = hi;
  assign md.LO     = lo;
  assign md.MD_OUT = dec && md.IR_FUNC == 6'h10 ? hi : dec && md.IR_FUNC == 6'h12 ? lo : 32'd0;
  // result is latched at acceptance so operand changes during the busy window are harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      res_we <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state  <= is_mul ? MULT : DIV;
        cnt    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        busy   <= 1'b1;
        res_hi <= is_mul ? prod[63:32] : rem;
        res_lo <= is_mul ? prod[31:0] : quo;
        res_we <= is_mul || md.B != 32'd0;
      end else if (is_mthi) begin
        hi <= md.A;
      end else if (is_mtlo) begin
        lo <= md.A;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (res_we) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_md_unit_e.sv
// tb_md_unit_e: randomized self-checking bench for md_unit_e against an arithmetic HI/LO model
module tb_md_unit_e;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  md_unit_e_if mi ();
  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .rst_n(rst_n), .md(mi));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output bit we, output logic [31:0] h, output logic [31:0] l);
    longint sa = $signed(a);
    longint sb = $signed(b);
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    we = 1'b1;
    h = m_hi;
    l = m_lo;
    if (f == 6'h18) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (f == 6'h19) begin
      p = ua * ub;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      we = 1'b0;
    end else if (f == 6'h1A) begin
      p = 64'(sa % sb);
      h = p[31:0];
      p = 64'(sa / sb);
      l = p[31:0];
    end else begin
      p = ua % ub;
      h = p[31:0];
      p = ua / ub;
      l = p[31:0];
    end
  endtask
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit collide);
    int n = f[1] ? 10 : 5;
    bit we;
    logic [31:0] eh, el;
    model(f, a, b, we, eh, el);
    @(negedge clk);
    mi.IR_OP = 6'h00;
    mi.IR_FUNC = f;
    mi.IR_VALID = 1'b1;
    mi.A = a;
    mi.B = b;
    #1 check("start", {31'd0, mi.START}, 32'd1);
    @(posedge clk);
    #1;
    for (int k = 1; k <= n; k++) begin
      check("busy", {31'd0, mi.BUSY}, 32'd1);
      mi.A = $urandom;
      mi.B = $urandom;
      mi.IR_VALID = collide && k <= 3;
      mi.IR_FUNC = k == 1 ? 6'h1A : k == 2 ? 6'h13 : 6'h12;
      if (collide && k <= 3) begin
        #1 check("col_start", {31'd0, mi.START}, 32'd0);
        if (k == 3) check("col_mflo", mi.MD_OUT, m_lo);
      end
      @(posedge clk);
      #1;
    end
    mi.IR_VALID = 1'b0;
    if (we) begin
      m_hi = eh;
      m_lo = el;
    end
    check("done_busy", {31'd0, mi.BUSY}, 32'd0);
    check("hi", mi.HI, m_hi);
    check("lo", mi.LO, m_lo);
  endtask
  task automatic mt(input logic [5:0] f, input logic [31:0] a);
    @(negedge clk);
    mi.IR_OP = 6'h00;
    mi.IR_FUNC = f;
    mi.IR_VALID = 1'b1;
    mi.A = a;
    #1 check(f == 6'h11 ? "mthi_nobypass" : "mtlo_nobypass", mi.MD_OUT, 32'd0);
    @(posedge clk);
    #1 mi.IR_VALID = 1'b0;
    if (f == 6'h11) m_hi = a;
    else m_lo = a;
    check("mt_hi", mi.HI, m_hi);
    check("mt_lo", mi.LO, m_lo);
  endtask
  task automatic mf(input logic [5:0] f);
    @(negedge clk);
    mi.IR_OP = 6'h00;
    mi.IR_FUNC = f;
    mi.IR_VALID = 1'b1;
    #1 check(f == 6'h10 ? "mfhi" : "mflo", mi.MD_OUT, f == 6'h10 ? m_hi : m_lo);
    mi.IR_VALID = 1'b0;
  endtask
  initial begin
    logic [5:0] ops [4];
    ops = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    mi.IR_OP = 6'h00;
    mi.IR_FUNC = 6'h00;
    mi.IR_VALID = 1'b0;
    mi.A = '0;
    mi.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", mi.HI, 32'd0);
    check("rst_lo", mi.LO, 32'd0);
    check("rst_busy", {31'd0, mi.BUSY}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'h18, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("t1_hi", mi.HI, 32'hFFFFFFFF);
    check("t1_lo", mi.LO, 32'hFFFFFFFA);
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("t2_hi", mi.HI, 32'hFFFFFFFE);
    check("t2_lo", mi.LO, 32'h00000001);
    issue(6'h1A, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("t3_lo", mi.LO, 32'hFFFFFFFD);
    check("t3_hi", mi.HI, 32'hFFFFFFFF);
    issue(6'h1B, 32'd7, 32'd2, 1'b0);
    check("t3u", {mi.HI[15:0], mi.LO[15:0]}, 32'h00010003);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo", mi.LO, 32'h80000000);
    check("ovf_hi", mi.HI, 32'd0);
    mt(6'h11, 32'h1234);
    mt(6'h13, 32'h5678);
    issue(6'h1A, 32'd99, 32'd0, 1'b0);
    check("dz_hi", mi.HI, 32'h1234);
    check("dz_lo", mi.LO, 32'h5678);
    mf(6'h10);
    mf(6'h12);
    issue(6'h18, 32'h00012345, 32'hFFFF0003, 1'b1);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 6 == 5) mt($urandom_range(0, 1) ? 6'h11 : 6'h13, $urandom);
      if (i % 4 == 3) a = $urandom_range(0, 1) ? 32'h80000000 : 32'hFFFFFFFF;
      issue(ops[$urandom_range(0, 3)], a, b, i % 5 == 2);
      mf($urandom_range(0, 1) ? 6'h10 : 6'h12);
    end
    @(negedge clk);
    mi.IR_OP = 6'h00;
    mi.IR_FUNC = 6'h1A;
    mi.IR_VALID = 1'b1;
    mi.A = 32'd100;
    mi.B = 32'd7;
    @(posedge clk);
    #1 mi.IR_VALID = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_busy", {31'd0, mi.BUSY}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, mi.BUSY}, 32'd0);
    check("mid_rst_hi", mi.HI, 32'd0);
    check("mid_rst_lo", mi.LO, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_hi", mi.HI, 32'd0);
    check("post_rst_lo", mi.LO, 32'd0);
    check("post_rst_busy", {31'd0, mi.BUSY}, 32'd0);
    @(negedge clk);
    mi.IR_FUNC = 6'h18;
    mi.IR_VALID = 1'b0;
    #1 check("invalid_start", {31'd0, mi.START}, 32'd0);
    mi.IR_OP = 6'h01;
    mi.IR_VALID = 1'b1;
    #1 check("op_nz_start", {31'd0, mi.START}, 32'd0);
    mi.IR_VALID = 1'b0;
    @(posedge clk);
    #1 check("invalid_busy", {31'd0, mi.BUSY}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/md_unit_e.md
Name: md_unit_e

Overview:
- Execute-stage multiply/divide unit. Sits beside the E-stage ALU.
- Consumes the same E-stage instruction fields (IR_OP, IR_FUNC) and operand values (A = rs, B = rt) that drive the ALU control decode.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- Exports START/BUSY so the hazard unit can stall younger HI/LO instructions.

Parameters:
MULT_CYCLES, 5, BUSY cycles for mult/multu (legal range >=1)
DIV_CYCLES, 10, BUSY cycles for div/divu (legal range >=1)

Ports:
clk  input  1  clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
IR_OP  input  6  E-stage opcode, IR[31:26]
IR_FUNC  input  6  E-stage function field, IR[5:0]
IR_VALID  input  1  E-stage instruction is real (0 = bubble or flushed)
A  input  32  forwarded rs value
B  input  32  forwarded rt value
START  output  1  combinational: a mult/multu/div/divu is accepted this cycle
BUSY  output  1  registered: operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MD_OUT  output  32  combinational read data for mfhi/mflo

Behaviour:
- Decode is valid only when IR_OP==0 and IR_VALID==1:
  - func 0x18 = mult, 0x19 = multu, 0x1A = div, 0x1B = divu
  - func 0x10 = mfhi, 0x11 = mthi, 0x12 = mflo, 0x13 = mtlo
- Reset (async, rst_n low): HI=0, LO=0, BUSY=0, state=IDLE, counter=0, internal result registers=0. Asserting reset mid-operation aborts the operation; no partial commit.
- FSM states: IDLE, MULT, DIV.
  - IDLE -> MULT: valid mult/multu, counter loaded with MULT_CYCLES.
  - IDLE -> DIV: valid div/divu, counter loaded with DIV_CYCLES.
  - MULT/DIV: counter decrements each cycle. When counter==1, commit the result to HI/LO on that edge and return to IDLE.
- START = IDLE & valid (mult|multu|div|divu). BUSY = (state != IDLE).
- Timing:
  - START high in cycle t.
  - BUSY high in cycles t+1 .. t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New HI/LO visible and BUSY low in cycle t+N+1.
- Operands A/B are captured at the START edge. Later changes to A/B have no effect on the result.
- Multiply: 64-bit product, HI = product[63:32], LO = product[31:0].
  - mult: signed x signed.
  - multu: unsigned x unsigned.
- Divide:
  - LO = quotient, HI = remainder.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor == 0 (div or divu): the operation still runs DIV_CYCLES with BUSY high; HI/LO are left unchanged at commit.
- mthi/mtlo: when IDLE, write A to HI/LO on the next edge.
- mfhi/mflo: MD_OUT = HI (mfhi), LO (mflo), else 0. Reads show register state only; there is no bypass of a same-cycle mthi/mtlo.
- While BUSY: mult/div/mt* are ignored, with no state change and START=0. mf* returns the current (old) HI/LO. The hazard unit guarantees these cases do not occur architecturally; the unit must still behave as stated.
- IR_VALID=0 suppresses all decodes. It does not cancel an operation already in flight.

Test Plan:
1. Reset then mult. Hold rst_n=0 -> HI=LO=0, BUSY=0. Release; mult A=0xFFFFFFFE(-2), B=3 -> START=1 for 1 cycle, BUSY=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, BUSY=0.
2. multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 BUSY cycles HI=0xFFFFFFFE, LO=0x00000001.
3. Signed and unsigned divide:
   - div A=0xFFFFFFF9(-7), B=2 -> after 10 BUSY cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu A=7, B=2 -> LO=3, HI=1.
   - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Divide by zero. mthi A=0x1234, mtlo A=0x5678, then div B=0 -> BUSY 10 cycles; HI=0x1234, LO=0x5678 unchanged. mfhi -> MD_OUT=0x1234.
5. Collisions while BUSY. Issue mult; during BUSY, present div, mtlo A=0xDEAD, and mflo.
   - div and mtlo: START=0, no effect.
   - mflo: MD_OUT = old LO.
   - Result equals the original mult only. Also change A/B mid-operation -> result unchanged.
6. Reset mid-divide. Assert rst_n=0 at BUSY cycle 4 -> immediately BUSY=0, HI=LO=0. After release, with no new op, HI/LO stay 0. IR_VALID=0 with mult func -> START=0.
